div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider in the EX stage; executes DIV/DIVU.
//  EX raises stallreq_for_ex to the pipeline controller while start_i=1 and
//    ready_o=0; result_o is written to HI/LO.
//  A pipeline flush (controller flush) drives annul_i and kills any division in flight.
// PARAMETERS
//  WIDTH  32  operand width; quotient and remainder are each WIDTH bits
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  start_i      in   1        division request; held high until ready_o is seen
//  annul_i      in   1        cancel request (pipeline flush)
//  signed_i     in   1        1 = DIV (two's complement), 0 = DIVU
//  opdata1_i    in   WIDTH    dividend
//  opdata2_i    in   WIDTH    divisor
//  result_o     out  2*WIDTH  {remainder(HI), quotient(LO)}
//  ready_o      out  1        result_o valid
//  stallreq_o   out  1        combinational: start_i & ~ready_o
// BEHAVIOUR
//  Interface: one clock, clk. Reset rst is asynchronous and active-high.
//  Reset values: state=FREE, cnt=0, result_o=0, ready_o=0, all datapath registers 0.
//  States:
//   FREE: start_i & ~annul_i & divisor==0 -> ZERO.
//     start_i & ~annul_i & divisor!=0 -> ON.
//     On the move to ON, latch |operands|: negate an operand when signed_i=1 and its MSB=1.
//     Also latch the sign flags and clear cnt.
//     With annul_i=1, start_i is ignored.
//   ZERO: -> END with result_o=0 (quotient=0, remainder=0).
//   ON: one quotient bit per cycle.
//     Shift {rem,quo} left by 1 and trial-subtract the divisor from rem.
//     If there is no borrow, keep the difference and set quo bit 0.
//     cnt increments each cycle. After WIDTH iterations (cnt==WIDTH-1 this cycle) -> END.
//     Sign fix-up on that same edge:
//       negate the quotient if the signs differ (signed only);
//       negate the remainder if the dividend was negative.
//     annul_i=1 in ON -> FREE next edge; partial result discarded; ready_o stays 0.
//   END: ready_o=1 and result_o stable for as long as start_i=1.
//     When start_i=0 -> FREE; ready_o=0 and result_o=0 on that edge.
//     annul_i=1 in END -> FREE.
//  Latency, from the edge that samples start_i in FREE:
//    nonzero divisor: ready_o high after WIDTH+1 edges (33);
//    zero divisor: ready_o high after 2 edges.
//  Operands and signed_i are captured once. Changes during ON are ignored.
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
//    This is modulo 2^WIDTH wrap; no trap.
//  Back-to-back divisions: a new start_i is accepted only in FREE.
//    That means at least one cycle with start_i=0 after END.
//  rst asserted mid-operation returns to FREE immediately (asynchronous); no result is produced.
//  All arithmetic is WIDTH+1 bits wide for the trial subtract; the borrow is the MSB.
// TESTING
//  1. DIVU 100/7, start_i held -> ready_o at edge 33; result_o={32'd2,32'd14}; stallreq_o low once ready.
//  2. DIV -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//     DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x1.
//  3. DIVU 5/0 -> ready_o at edge 2; result_o=0.
//     Drop start_i -> FREE, ready_o=0 next edge.
//  4. Start 0xFFFFFFFF/3; pulse annul_i at edge 10 -> ready_o never rises.
//     A following 9/3 yields {0,3} at edge 33.
//  5. DIV 0x80000000/0xFFFFFFFF -> {32'h0,32'h80000000}.
//     DIVU with the same operands -> {32'h80000000,32'h0}.
//  6. Assert rst async at ON cycle 15 -> outputs 0 immediately.
//     Change opdata2_i during ON in another run -> result unaffected.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after WIDTH iterations; divide-by-zero short-circuits to 0.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stallreq_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_ZERO = 2'd1,
    ST_ON   = 2'd2,
    ST_END  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_rem;
  logic [WIDTH-1:0]      r_quo;
  logic [WIDTH-1:0]      r_dvs;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [2*WIDTH-1:0]    r_result;
  logic                  r_ready;

  logic                  w_go;
  logic                  w_dvs_zero;
  logic                  w_last;
  logic [WIDTH-1:0]      w_abs1;
  logic [WIDTH-1:0]      w_abs2;
  logic [WIDTH:0]        w_trial;
  logic [WIDTH:0]        w_diff;
  logic                  w_borrow;
  logic [WIDTH-1:0]      w_rem_nx;
  logic [WIDTH-1:0]      w_quo_nx;
  logic [WIDTH-1:0]      w_rem_fix;
  logic [WIDTH-1:0]      w_quo_fix;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  assign w_go       = start_i & ~annul_i;
  assign w_dvs_zero = (opdata2_i == '0);
  assign w_last     = (r_cnt == LAST_CNT);

  assign w_abs1 = (signed_i & opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
  assign w_abs2 = (signed_i & opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;

  // Shift in the next dividend bit and trial-subtract; the extra MSB is the borrow.
  assign w_trial  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_trial - {1'b0, r_dvs};
  assign w_borrow = w_diff[WIDTH];
  assign w_rem_nx = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_borrow};

  assign w_quo_fix = r_neg_q ? negate(w_quo_nx) : w_quo_nx;
  assign w_rem_fix = r_neg_r ? negate(w_rem_nx) : w_rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FREE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_FREE: begin
        if (w_go) begin
          w_state_nx = w_dvs_zero ? ST_ZERO : ST_ON;
        end
      end
      ST_ZERO: w_state_nx = ST_END;
      ST_ON: begin
        if (annul_i) begin
          w_state_nx = ST_FREE;
        end else if (w_last) begin
          w_state_nx = ST_END;
        end
      end
      ST_END: begin
        if (annul_i | ~start_i) begin
          w_state_nx = ST_FREE;
        end
      end
      default: w_state_nx = ST_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_FREE: begin
          // Operands and sign flags are captured once; later input changes are ignored.
          if (w_go && !w_dvs_zero) begin
            r_rem   <= '0;
            r_quo   <= w_abs1;
            r_dvs   <= w_abs2;
            r_neg_q <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_r <= signed_i & opdata1_i[WIDTH-1];
            r_cnt   <= '0;
          end
        end
        ST_ZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
        end
        ST_ON: begin
          if (!annul_i) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= 1'b1;
            end
          end
        end
        ST_END: begin
          if (annul_i | ~start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = start_i & ~r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_i;
  logic               annul_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit integer division, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction: start held until ready, hold one extra cycle, then release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble);
    int edges;
    int exp_lat;
    logic [63:0] exp_res;
    exp_res = ref_div(sgn, a, b);
    exp_lat = (b == 32'h0) ? 2 : WIDTH + 1;
    @(negedge clk);
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    #1;
    chk({tag, "_stall_busy"}, {63'h0, stallreq_o}, 64'h1);
    edges = 0;
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready_o) break;
      if (scramble && edges == 5) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~signed_i;
      end
    end
    chk({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_stall_ready"}, {63'h0, stallreq_o}, 64'h0);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp_res[62:0]});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_release"}, {63'h0, ready_o} | result_o, 64'h0);
  endtask

  initial begin
    int hits;
    logic [31:0] ra, rb;
    logic        rs;

    rst       = 1'b1;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    #1;
    chk("reset_state", {63'h0, ready_o} | result_o, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    chk("divu_100_7_model", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0);
    run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 1'b0);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div("div_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);

    // Flush in flight: start and annul drop/rise together at edge 10.
    @(negedge clk);
    signed_i  = 1'b0;
    opdata1_i = 32'hFFFF_FFFF;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    hits = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) hits++;
    end
    chk("annul_no_ready", 64'(hits), 64'h0);
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 1'b0);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    signed_i  = 1'b0;
    opdata1_i = 32'd12345;
    opdata2_i = 32'd17;
    start_i   = 1'b1;
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out", {63'h0, ready_o} | result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) hits++;
    end
    chk("rst_no_result", 64'(hits), 64'h0);

    run_div("scramble_ops", 1'b1, 32'hFFFF_FC18, 32'd33, 1'b1);

    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 255);
        2:       rb = -($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), rs, ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
